// File: rtl/cpu_defs.sv
// Shared definitions for the RV32I pipeline control blocks: register-index
// width and the ALU operand forward-select encoding.
package cpu_defs;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_Y   = 2'b01,
    FWD_MD  = 2'b10
  } fwd_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forward selection: picks the youngest in-flight producer of rs.
module fwd_sel
  import cpu_defs::*;
#(
  parameter int unsigned REG_AW = cpu_defs::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  input  logic              ex_v,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  output fwd_t              sel,
  output logic              hit_ex
);

  logic hit_mem;

  // x0 is hardwired to zero, so a write to it never produces a forward.
  always_comb begin
    hit_ex  = used & ex_v  & ex_we  & (ex_rd  != '0) & (ex_rd  == rs);
    hit_mem = used & mem_v & mem_we & (mem_rd != '0) & (mem_rd == rs);
    sel     = FWD_REG;
    if (hit_ex) begin
      sel = FWD_Y;
    end else if (hit_mem) begin
      sel = FWD_MD;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage RV32I core: shadows EX/MEM
// destination info, registers ALU forward selects, and drives stall/flush.
module hazard_fwd_unit
  import cpu_defs::*;
#(
  parameter int unsigned REG_AW = cpu_defs::REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              br_taken,
  output logic [1:0]        afwd,
  output logic [1:0]        bfwd,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              ex_v, ex_we, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_v, mem_we;
  logic [REG_AW-1:0] mem_rd;

  fwd_t a_sel, b_sel;
  logic a_hit_ex, b_hit_ex;
  logic load_use, issue;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs     (id_rs1),
    .used   (id_rs1_used),
    .ex_v   (ex_v),
    .ex_rd  (ex_rd),
    .ex_we  (ex_we),
    .mem_v  (mem_v),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .sel    (a_sel),
    .hit_ex (a_hit_ex)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs     (id_rs2),
    .used   (id_rs2_used),
    .ex_v   (ex_v),
    .ex_rd  (ex_rd),
    .ex_we  (ex_we),
    .mem_v  (mem_v),
    .mem_rd (mem_rd),
    .mem_we (mem_we),
    .sel    (b_sel),
    .hit_ex (b_hit_ex)
  );

  // A redirect discards the ID instruction, so it overrides a load-use stall.
  always_comb begin
    load_use  = id_valid & ex_v & ex_ld & (a_hit_ex | b_hit_ex);
    issue     = id_valid & ~load_use & ~br_taken;
    stall_if  = load_use & ~br_taken;
    flush_id  = br_taken;
    bubble_ex = ~issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v      <= 1'b0;
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_v     <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      afwd      <= FWD_REG;
      bfwd      <= FWD_REG;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      ex_v   <= issue;
      ex_rd  <= issue ? id_rd : '0;
      ex_we  <= issue & id_reg_write;
      ex_ld  <= issue & id_mem_read;
      afwd   <= issue ? a_sel : FWD_REG;
      bfwd   <= issue ? b_sel : FWD_REG;
      if (stall_if && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_id && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed pipeline scenarios plus
// random traffic checked against an instruction-slot reference model.
module tb_hazard_fwd_unit;

  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic          br_taken;
  logic [1:0]    afwd, bfwd;
  logic          stall_if, bubble_ex, flush_id;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_fwd_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .br_taken     (br_taken),
    .afwd         (afwd),
    .bfwd         (bfwd),
    .stall_if     (stall_if),
    .bubble_ex    (bubble_ex),
    .flush_id     (flush_id),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: slot 0 is the instruction in EX, slot 1 the one in MEM.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } slot_t;

  typedef struct {
    string tag;
    bit    stall;
    bit    bubble;
    bit    flush;
  } comb_t;

  typedef struct {
    string tag;
    int    a;
    int    b;
    int    sc;
    int    fc;
  } reg_t;

  slot_t pipe[2];
  bit    known = 1'b0;
  int    m_scnt, m_fcnt;
  comb_t comb_q[$];
  reg_t  reg_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  // 0 = no producer, 1 = EX result, 2 = MEM writeback; youngest slot first.
  function automatic int producer(int r, bit u);
    if (!u || r == 0) return 0;
    for (int i = 0; i < 2; i++) begin
      if (pipe[i].v && pipe[i].we && pipe[i].rd == r) return i + 1;
    end
    return 0;
  endfunction

  task automatic cycle(input string tag, input bit r, input bit v,
                       input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit br);
    bit lu, iss;
    int a, b;
    comb_t c;
    reg_t  q;
    @(negedge clk);
    rst = r; id_valid = v; br_taken = br;
    id_rs1 = AW'(r1); id_rs1_used = u1; id_rs2 = AW'(r2); id_rs2_used = u2;
    id_rd = AW'(rd); id_reg_write = we; id_mem_read = ld;
    #1;
    if (known) begin
      lu  = v && pipe[0].ld && (producer(r1, u1) == 1 || producer(r2, u2) == 1);
      iss = v && !lu && !br;
      c.tag = tag; c.stall = lu && !br; c.flush = br; c.bubble = !iss;
      comb_q.push_back(c);
      a = iss ? producer(r1, u1) : 0;
      b = iss ? producer(r2, u2) : 0;
      if (r) begin
        pipe[0] = '{0, 0, 0, 0}; pipe[1] = '{0, 0, 0, 0};
        a = 0; b = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
        pipe[1] = pipe[0];
        pipe[0] = iss ? slot_t'{1, rd, we, ld} : slot_t'{0, 0, 0, 0};
        if (c.stall && m_scnt < CMAX) m_scnt++;
        if (c.flush && m_fcnt < CMAX) m_fcnt++;
      end
    end else begin
      // Before the first reset edge nothing is defined; only the reset result is checked.
      pipe[0] = '{0, 0, 0, 0}; pipe[1] = '{0, 0, 0, 0};
      a = 0; b = 0; m_scnt = 0; m_fcnt = 0;
      known = r;
    end
    if (known) begin
      q.tag = tag; q.a = a; q.b = b; q.sc = m_scnt; q.fc = m_fcnt;
      reg_q.push_back(q);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: combinational controls just after the driver settles inputs,
  // registered outputs just after the following rising edge.
  initial begin
    comb_t c;
    reg_t  q;
    while (!done) begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk({c.tag, ".stall_if"},  int'(stall_if),  int'(c.stall));
        chk({c.tag, ".bubble_ex"}, int'(bubble_ex), int'(c.bubble));
        chk({c.tag, ".flush_id"},  int'(flush_id),  int'(c.flush));
      end
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        q = reg_q.pop_front();
        chk({q.tag, ".afwd"},      int'(afwd),      q.a);
        chk({q.tag, ".bfwd"},      int'(bfwd),      q.b);
        chk({q.tag, ".stall_cnt"}, int'(stall_cnt), q.sc);
        chk({q.tag, ".flush_cnt"}, int'(flush_cnt), q.fc);
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; br_taken = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;

    cycle("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // addi x5 then add x6,x5,x7: EX forward on A
    cycle("addi_x5",  0, 1, 1, 1, 0, 0, 5, 1, 0, 0);
    cycle("add_ex_a", 0, 1, 5, 1, 7, 1, 6, 1, 0, 0);
    // producer x5 two ahead, consumer reads it on rs2: MEM forward on B
    cycle("prod_x5",  0, 1, 1, 1, 2, 1, 5, 1, 0, 0);
    cycle("nop",      0, 1, 8, 1, 9, 1, 10, 1, 0, 0);
    cycle("mem_b",    0, 1, 3, 1, 5, 1, 11, 1, 0, 0);
    // lw x5 then add x6,x5,x5: one stall, then MD forward on both
    cycle("lw_x5",    0, 1, 2, 1, 0, 0, 5, 1, 1, 0);
    cycle("lu_stall", 0, 1, 5, 1, 5, 1, 6, 1, 0, 0);
    cycle("lu_issue", 0, 1, 5, 1, 5, 1, 6, 1, 0, 0);
    // writes to x0 never forward
    cycle("w_x0_a",   0, 1, 1, 1, 1, 1, 0, 1, 1, 0);
    cycle("w_x0_b",   0, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    cycle("rd_x0",    0, 1, 0, 1, 0, 1, 12, 1, 0, 0);
    // branch redirect coincident with load-use: flush only
    cycle("lw_x7",    0, 1, 2, 1, 0, 0, 7, 1, 1, 0);
    cycle("br_lu",    0, 1, 7, 1, 7, 1, 8, 1, 0, 1);
    cycle("after_br", 0, 1, 7, 1, 0, 0, 9, 1, 0, 0);

    // 20 forced stalls to saturate the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      cycle("sat_lw",    0, 1, 1, 0, 1, 0, 5, 1, 1, 0);
      cycle("sat_stall", 0, 1, 5, 1, 3, 0, 6, 1, 0, 0);
    end
    cycle("sat_lw",     0, 1, 1, 0, 1, 0, 5, 1, 1, 0);
    cycle("rst_stall",  1, 1, 5, 1, 3, 0, 6, 1, 0, 0);
    cycle("post_rst",   0, 1, 5, 1, 5, 1, 6, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 7) != 0),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    done = 1'b1;
    chk("queues_drained", comb_q.size() + reg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
